// File: rtl/mem_access_ctrl.sv
// OTTER data-memory access sequencer: one request/ack bus transaction per
// access, with alignment checking, lane steering and load formatting.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        misalign;
  logic        expire;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [15:0] lane;
  logic [31:0] ld_fmt;

  always_comb begin
    misalign = 1'b0;
    be_nx    = 4'b0000;
    wd_nx    = 32'd0;
    unique case (size)
      2'b00: begin
        be_nx = 4'b0001 << addr[1:0];
        wd_nx = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign = addr[0];
        be_nx    = 4'b0011 << addr[1:0];
        wd_nx    = {2{wdata[15:0]}};
      end
      2'b10: begin
        misalign = |addr[1:0];
        be_nx    = 4'b1111;
        wd_nx    = wdata;
      end
      default: misalign = 1'b1;
    endcase
    if (!we) wd_nx = 32'd0;
  end

  // Lane is picked using the captured offset, never the live address.
  always_comb begin
    lane   = 16'(mem_rdata >> {off_q, 3'b000});
    ld_fmt = mem_rdata;
    unique case (size_q)
      2'b00:   ld_fmt = {{24{~sign_q & lane[7]}}, lane[7:0]};
      2'b01:   ld_fmt = {{16{~sign_q & lane[15]}}, lane};
      default: ld_fmt = mem_rdata;
    endcase
  end

  assign expire = (cnt == LAST) && !mem_ack;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = misalign ? DONE : ACCESS;
      ACCESS:  if (mem_ack || expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= 16'd0;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      rdata       <= 32'd0;
      fault_cause <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_be      <= 4'b0000;
      mem_wdata   <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            we_q   <= we;
            sign_q <= sign;
            size_q <= size;
            off_q  <= addr[1:0];
            cnt    <= 16'd0;
            if (misalign) begin
              fault_cause <= 2'b01;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_nx;
              mem_wdata <= wd_nx;
            end
          end
        end
        ACCESS: begin
          if (mem_ack || expire) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'b0000;
            mem_wdata   <= 32'd0;
            fault_cause <= mem_ack ? 2'b00 : 2'b10;
            if (mem_ack && !we_q) rdata <= ld_fmt;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign fault = done && (fault_cause != 2'b00);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed checks of mem_access_ctrl against a
// transaction-level model of alignment, lanes, formatting and timing.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_rdata;
  logic [1:0]  m_cause;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we),
    .addr(addr), .wdata(wdata), .size(size), .sign(sign),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w,
                                      input int off,
                                      input logic [1:0] sz,
                                      input logic sgn);
    longint v;
    if (sz == 2'b10) return w;
    if (sz == 2'b00) begin
      v = longint'((w >> (8 * off)) % 256);
      if (!sgn && v >= 128) v = v - 256;
    end else begin
      v = longint'((w >> (8 * off)) % 65536);
      if (!sgn && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz,
                                        input int off);
    if (sz == 2'b00) return 4'(1 << off);
    if (sz == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz,
                                         input logic [31:0] w);
    if (sz == 2'b00) return 32'(w % 256) * 32'h0101_0101;
    if (sz == 2'b01) return 32'(w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".req"}, 32'(mem_req), 0);
    check({tag, ".be"}, 32'(mem_be), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".fault"}, 32'(fault), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle
  // negedge afterwards so consecutive calls are back-to-back.
  task automatic run_access(input logic a_we,
                            input logic [31:0] a_addr,
                            input logic [31:0] a_wd,
                            input logic [1:0] a_sz,
                            input logic a_sgn,
                            input int ack_at,
                            input logic [31:0] bus_rd,
                            input bit noise);
    int off;
    bit mis;
    bit ok;
    int done_at;
    logic [31:0] old_rd;
    logic [31:0] new_rd;
    off = int'(a_addr % 4);
    mis = (a_sz == 2'b11) || (a_sz == 2'b01 && off % 2 != 0) ||
          (a_sz == 2'b10 && off != 0);
    ok  = !mis && ack_at >= 1 && ack_at <= TMO;
    done_at = mis ? 1 : (ok ? ack_at + 1 : TMO + 1);
    old_rd = m_rdata;
    new_rd = (ok && !a_we) ? fmt(bus_rd, off, a_sz, a_sgn) : m_rdata;
    start = 1'b1; we = a_we; addr = a_addr; wdata = a_wd;
    size = a_sz; sign = a_sgn; mem_ack = 1'b0; mem_rdata = bus_rd;
    @(negedge clk);
    for (int cyc = 1; cyc <= done_at; cyc++) begin
      if (!mis && cyc < done_at) begin
        check("req", 32'(mem_req), 1);
        check("we", 32'(mem_we), 32'(a_we));
        check("addr", mem_addr, a_addr & 32'hFFFF_FFFC);
        check("be", 32'(mem_be), 32'(exp_be(a_sz, off)));
        if (a_we) check("wdata", mem_wdata, exp_wd(a_sz, a_wd));
      end else begin
        check("req_off", 32'(mem_req), 0);
        check("be_off", 32'(mem_be), 0);
      end
      check("busy", 32'(busy), 1);
      check("done", 32'(done), 32'(cyc == done_at));
      check("fault", 32'(fault), 32'(cyc == done_at && !ok));
      if (cyc == done_at)
        check("cause", 32'(fault_cause), mis ? 1 : (ok ? 0 : 2));
      else
        check("cause_hold", 32'(fault_cause), 32'(m_cause));
      check("rdata", rdata, cyc >= done_at ? new_rd : old_rd);
      start = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        we = 1'($urandom); addr = $urandom; wdata = $urandom;
        size = 2'($urandom); sign = 1'($urandom);
      end
      mem_ack = (cyc == ack_at);
      @(negedge clk);
    end
    m_rdata = new_rd;
    m_cause = mis ? 2'd1 : (ok ? 2'd0 : 2'd2);
    check("idle_busy", 32'(busy), 0);
    check_quiet("idle");
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    rst_n = 1'b0; start = 1'b0; we = 1'b0; addr = 0; wdata = 0;
    size = 0; sign = 0; mem_ack = 1'b0; mem_rdata = 0;
    m_rdata = 0; m_cause = 0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst.busy", 32'(busy), 0);
    check("rst.rdata", rdata, 0);
    check("rst.cause", 32'(fault_cause), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access(0, 32'h1003, 0, 2'b00, 0, 1, 32'h80FF_FFFF, 0);
    check("lb_signed", rdata, 32'hFFFF_FF80);
    run_access(0, 32'h1003, 0, 2'b00, 1, 1, 32'h80FF_FFFF, 0);
    check("lbu", rdata, 32'h0000_0080);
    run_access(1, 32'h2002, 32'h1234_ABCD, 2'b01, 0, 4, 32'h5555_5555, 0);
    check("sh_keep", rdata, 32'h0000_0080);
    run_access(0, 32'h3001, 0, 2'b10, 0, 1, 32'h1, 0);
    run_access(0, 32'h3000, 0, 2'b11, 0, 1, 32'h1, 0);
    run_access(0, 32'h4000, 0, 2'b10, 0, 0, 32'h1, 0);
    run_access(0, 32'h4000, 0, 2'b10, 0, TMO, 32'hCAFE_F00D, 1);
    check("lw_last", rdata, 32'hCAFE_F00D);
    run_access(0, 32'h5004, 0, 2'b01, 1, 2, 32'h9876_5432, 1);

    // Reset during the second access cycle, followed by a stale ack.
    start = 1'b1; we = 1'b0; addr = 32'h6000; size = 2'b10;
    sign = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet("mid_rst");
    check("mid_rst.busy", 32'(busy), 0);
    check("mid_rst.rdata", rdata, 0);
    check("mid_rst.cause", 32'(fault_cause), 0);
    rst_n = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check_quiet("late_ack");
    check("late_ack.busy", 32'(busy), 0);
    mem_ack = 1'b0;
    m_rdata = 0; m_cause = 0;
    run_access(0, 32'h6002, 0, 2'b01, 0, 1, 32'h8001_0000, 0);
    check("post_rst", rdata, 32'hFFFF_8001);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz == 2'b01) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0 && sz == 2'b10) a[1:0] = 2'b00;
      run_access(1'($urandom), a, $urandom, sz, 1'($urandom),
                 $urandom_range(0, TMO + 2), $urandom,
                 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for all OTTER data-memory loads and stores. It sits between the multicycle control unit and the data-memory bus. It accepts one access request at a time, checks alignment, and drives a single request/acknowledge transaction with byte enables and lane-replicated store data. It returns size- and sign-formatted load data, or a fault (misaligned/timeout) with a one-cycle completion pulse.

## Interface
- `TIMEOUT`, default 255: max cycles `mem_req` is held without `mem_ack` before a timeout fault; legal range 1..65535.

- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin access; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `sign` in 1: 0 = signed, 1 = unsigned; loads only.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: formatted load data; valid from `done` until the next load completes.
- `fault` out 1: qualifies `done`; high if the access failed.
- `fault_cause` out 2: 00 none, 01 misaligned/illegal size, 10 timeout; held until next `done`.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write strobe.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus acknowledge; ignored outside ACCESS.
- `mem_rdata` in 32: bus read data; valid with `mem_ack`.

## Operation
- FSM states:
  - IDLE:
    - `start`=1 with aligned access → ACCESS.
    - `start`=1 with misaligned access or size 11 → DONE with fault cause 01.
  - ACCESS:
    - `mem_ack`=1 → DONE, no fault.
    - Timeout expiry → DONE, fault cause 10.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- Request capture: `we`, `addr`, `wdata`, `size`, `sign` are registered on the accepting `start` edge. They are never re-sampled mid-access. `start` outside IDLE is ignored; no queueing.
- Alignment rules:
  - Byte: always legal.
  - Half: requires `addr[0]`=0.
  - Word: requires `addr[1:0]`=00.
  - Misaligned accesses never assert `mem_req`.
- Byte enables:
  - Byte: 0001 << `addr[1:0]`.
  - Half: 0011 << `addr[1:0]`.
  - Word: 1111.
  - `mem_be`=0000 whenever `mem_req`=0.
- Store data replication:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- Load formatting: on `mem_ack` in ACCESS with `we`=0, take the lane `mem_rdata[8*addr[1:0] +: 8 or 16]` and register it into `rdata`.
  - Byte/half: sign-extend (`sign`=0) or zero-extend (`sign`=1) to 32 bits.
  - Word: `mem_rdata` unchanged.
- `rdata` is unchanged by stores and by faulted accesses.
- Bus outputs (`mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`):
  - Registered.
  - Stable for the whole ACCESS interval.
  - Deasserted (all zero) in IDLE and DONE.
- Timeout counter: 16 bits, cleared on entry to ACCESS, increments each ACCESS cycle without `mem_ack`.
  - Expiry occurs when the counter equals `TIMEOUT`-1 and `mem_ack`=0, so `mem_req` is high for at most `TIMEOUT` cycles.
  - `mem_ack` on the final cycle wins: the access completes normally.

## Timing
- Reset: on any rising edge with `rst_n`=0, state→IDLE. All outputs read 0 the following cycle, including `rdata` and `fault_cause`.
- Reset mid-ACCESS:
  - Aborts with no `done`.
  - `mem_req` is low the next cycle.
  - A late `mem_ack` is ignored.
- Aligned access, `start` at cycle 0:
  - `mem_req`=1 from cycle 1.
  - If `mem_ack` is at cycle k≥1, `done`/`rdata` are valid at cycle k+1 and `busy` falls at cycle k+2.
  - Minimum latency is 2 cycles.
- Misaligned access, `start` at cycle 0: `done`=1, `fault`=1 at cycle 1; no bus activity.
- Timeout, `start` at cycle 0: `mem_req` is high cycles 1..`TIMEOUT`; `done`=1 with cause 10 at cycle `TIMEOUT`+1.
- Back-to-back: the earliest next `start` is accepted in the first IDLE cycle after DONE. `start` held high continuously is re-accepted each time IDLE is reached.
- `fault`=0 in every cycle where `done`=0.

## Test plan
- Load byte, `addr`=0x1003, `sign`=0, `mem_rdata`=0x80FFFFFF, ack 1 cycle after `mem_req` → `mem_addr`=0x1000, `mem_be`=1000, `rdata`=0xFFFFFF80, `done` 2 cycles after `start`; repeat with `sign`=1 → `rdata`=0x00000080.
- Store half, `addr`=0x2002, `wdata`=0x1234ABCD, ack delayed 3 cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD stable for 4 cycles, `done` 5 cycles after `start`, `rdata` unchanged.
- Load word, `addr`=0x3001 → `done`/`fault` at cycle 1, `fault_cause`=01, `mem_req` never asserted; `size`=11 at an aligned address → same result.
- `TIMEOUT`=4, no ack → `mem_req` high exactly 4 cycles, `done` with `fault_cause`=10 at cycle 5; ack on the 4th `mem_req` cycle → normal completion, `fault`=0.
- `start` pulsed during ACCESS and during DONE → ignored, single `done`; a new `start` on the first IDLE cycle is accepted with correct new `addr`.
- `rst_n`=0 during the 2nd ACCESS cycle, then ack → no `done`, all outputs 0 next cycle, next load completes normally.
